program_loader: RTL

//  Synthesizable boot loader that streams program words into the core's instruction memory.
//  - Replaces hierarchical instr_mem pokes from the bench.
//  - Holds the CPU in reset until a complete, optionally checksummed, image is written, then releases it.
//  - Sits between a host/debug word stream and the instruction-memory write port, beside cpu_top.

---
 rtl/loader_pkg.sv | 15 +
 rtl/loader_checksum.sv | 37 +++
 rtl/program_loader.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/loader_pkg.sv
// Shared types and constants for the program loader.
//   loader_state_t : loader FSM states (IDLE, LOAD, CHECK, RUN)
//   WORD_BYTES     : byte stride between consecutive instruction words
package loader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        CHECK = 2'd2,
        RUN   = 2'd3
    } loader_state_t;

    localparam int WORD_BYTES = 4;

endpackage

// File: rtl/loader_checksum.sv
// Running image checksum for the program loader.
// Keeps sum = sum of accumulated words mod 2**DATA_WIDTH and compares it
// against a candidate word.
// Ports:
//   i_clk, i_reset_n : clock, asynchronous active-low reset
//   i_clear          : zero the sum (new session); wins over i_acc_en
//   i_acc_en         : add i_acc_data to the sum this cycle
//   i_acc_data       : word to accumulate
//   i_cmp_data       : candidate checksum word
//   o_match          : combinational, i_cmp_data equals the current sum
module loader_checksum #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_clear,
    input  logic                  i_acc_en,
    input  logic [DATA_WIDTH-1:0] i_acc_data,
    input  logic [DATA_WIDTH-1:0] i_cmp_data,
    output logic                  o_match
);

    logic [DATA_WIDTH-1:0] sum_q;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sum_q <= '0;
        end else if (i_clear) begin
            sum_q <= '0;
        end else if (i_acc_en) begin
            sum_q <= sum_q + i_acc_data;
        end
    end

    assign o_match = (i_cmp_data == sum_q);

endmodule

// File: rtl/program_loader.sv
// Boot loader: streams program words into the instruction memory and holds
// the CPU in reset until a complete image has been written.
// Optional feature macro: PROGRAM_LOADER_CHECKSUM_EN. When defined, one extra
// stream word after the image carries the expected sum of the image words;
// the core is released only if it matches.
// Ports:
//   i_clk, i_reset_n     : clock (rising edge), asynchronous active-low reset
//   i_start              : request a new load session (honoured in IDLE/RUN)
//   i_word_count         : image length in words, sampled with i_start
//   i_s_data/i_s_valid   : incoming word stream
//   o_s_ready            : loader accepts a stream word
//   o_mem_we/addr/wdata  : instruction-memory write port (byte address)
//   o_core_reset_n       : active-low reset to the core
//   o_busy               : session in progress (LOAD or CHECK)
//   o_done               : one-cycle pulse when the core is released
//   o_error              : one-cycle pulse on bad count or checksum mismatch
//   o_state              : current FSM state (debug)
//
// Stream handshake: a word transfers in any cycle where i_s_valid and
// o_s_ready are both high at the rising edge. o_s_ready does not depend on
// i_s_valid; the source may raise or drop i_s_valid freely and must hold
// i_s_data stable while i_s_valid is high and no transfer has happened.
module program_loader
    import loader_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int MAX_WORDS  = 256,
    parameter int BASE_ADDR  = 0
) (
    input  logic                               i_clk,
    input  logic                               i_reset_n,
    input  logic                               i_start,
    input  logic [$clog2(MAX_WORDS+1)-1:0]     i_word_count,
    input  logic [DATA_WIDTH-1:0]              i_s_data,
    input  logic                               i_s_valid,
    output logic                               o_s_ready,
    output logic                               o_mem_we,
    output logic [ADDR_WIDTH-1:0]              o_mem_addr,
    output logic [DATA_WIDTH-1:0]              o_mem_wdata,
    output logic                               o_core_reset_n,
    output logic                               o_busy,
    output logic                               o_done,
    output logic                               o_error,
    output loader_state_t                      o_state
);

    localparam int CW = $clog2(MAX_WORDS + 1);
    localparam logic [CW-1:0]         MAX_CNT = CW'(MAX_WORDS);
    localparam logic [ADDR_WIDTH-1:0] BASE_A  = ADDR_WIDTH'(BASE_ADDR);

    // The whole image must fit in the write port; addresses never wrap.
    if (BASE_ADDR + WORD_BYTES * (MAX_WORDS - 1) >= (1 << ADDR_WIDTH)) begin : g_addr_range_check
        $error("program_loader: image does not fit in ADDR_WIDTH address space");
    end

    loader_state_t state_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] idx_q;

    logic hs;
    logic count_ok;
    logic last_word;

    assign hs        = i_s_valid && o_s_ready;
    assign count_ok  = (i_word_count != '0) && (i_word_count <= MAX_CNT);
    assign last_word = (idx_q == count_q - 1'b1);
    assign o_state   = state_q;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic sum_match;
    logic start_ok;

    assign start_ok = i_start && count_ok && (state_q == IDLE || state_q == RUN);

    loader_checksum #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_checksum (
        .i_clk      (i_clk),
        .i_reset_n  (i_reset_n),
        .i_clear    (start_ok),
        .i_acc_en   (hs && (state_q == LOAD)),
        .i_acc_data (i_s_data),
        .i_cmp_data (i_s_data),
        .o_match    (sum_match)
    );
`else
    // Set on the last image handshake: the write goes out in the next cycle,
    // the core is released one cycle after that.
    logic release_q;
`endif

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q        <= IDLE;
            count_q        <= '0;
            idx_q          <= '0;
            o_s_ready      <= 1'b0;
            o_mem_we       <= 1'b0;
            o_mem_addr     <= '0;
            o_mem_wdata    <= '0;
            o_core_reset_n <= 1'b0;
            o_busy         <= 1'b0;
            o_done         <= 1'b0;
            o_error        <= 1'b0;
`ifndef PROGRAM_LOADER_CHECKSUM_EN
            release_q      <= 1'b0;
`endif
        end else begin
            // Pulse outputs default low every cycle.
            o_mem_we <= 1'b0;
            o_done   <= 1'b0;
            o_error  <= 1'b0;

            case (state_q)
                IDLE, RUN: begin
                    if (i_start) begin
                        if (count_ok) begin
                            state_q        <= LOAD;
                            count_q        <= i_word_count;
                            idx_q          <= '0;
                            o_s_ready      <= 1'b1;
                            o_busy         <= 1'b1;
                            o_core_reset_n <= 1'b0;
                        end else begin
                            o_error <= 1'b1;
                        end
                    end
                end

                LOAD: begin
`ifndef PROGRAM_LOADER_CHECKSUM_EN
                    if (release_q) begin
                        release_q      <= 1'b0;
                        state_q        <= RUN;
                        o_core_reset_n <= 1'b1;
                        o_done         <= 1'b1;
                        o_busy         <= 1'b0;
                    end
`endif
                    if (hs) begin
                        o_mem_we    <= 1'b1;
                        o_mem_addr  <= BASE_A + ADDR_WIDTH'(idx_q) * ADDR_WIDTH'(WORD_BYTES);
                        o_mem_wdata <= i_s_data;
                        idx_q       <= idx_q + 1'b1;
                        if (last_word) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                            state_q <= CHECK;
`else
                            o_s_ready <= 1'b0;
                            release_q <= 1'b1;
`endif
                        end
                    end
                end

                CHECK: begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    // The checksum word is consumed here and never written.
                    if (hs) begin
                        o_s_ready <= 1'b0;
                        o_busy    <= 1'b0;
                        if (sum_match) begin
                            state_q        <= RUN;
                            o_core_reset_n <= 1'b1;
                            o_done         <= 1'b1;
                        end else begin
                            state_q <= IDLE;
                            o_error <= 1'b1;
                        end
                    end
`else
                    state_q   <= IDLE;
                    o_s_ready <= 1'b0;
                    o_busy    <= 1'b0;
`endif
                end

                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
